// File: rtl/nmi_xbar_demux.sv
// Native-memory-interface 1-to-N demultiplexer with base/mask address map,
// a registered decode stage, watchdog timeout and decode-miss error reporting.
module nmi_xbar_demux #(
    parameter int                    SLV_NUM     = 4,
    parameter logic [SLV_NUM*32-1:0] SLV_BASE    = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
    parameter logic [SLV_NUM*32-1:0] SLV_MASK    = {4{32'hF000_0000}},
    parameter int                    TIMEOUT_CYC = 1024,
    parameter logic [31:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    mstr_valid_i,
    input  logic [31:0]             mstr_addr_i,
    input  logic [31:0]             mstr_wdata_i,
    input  logic [3:0]              mstr_wstrb_i,
    output logic [31:0]             mstr_rdata_o,
    output logic                    mstr_ready_o,
    output logic                    mstr_err_o,
    output logic [SLV_NUM-1:0]      slv_valid_o,
    output logic [31:0]             slv_addr_o,
    output logic [31:0]             slv_wdata_o,
    output logic [3:0]              slv_wstrb_o,
    input  logic [SLV_NUM*32-1:0]   slv_rdata_i,
    input  logic [SLV_NUM-1:0]      slv_ready_i,
    output logic [15:0]             err_cnt_o
);

    localparam int          SEL_W   = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [15:0]        err_cnt_q, err_cnt_d;

    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic               sel_ready;
    logic [31:0]        sel_rdata;
    logic               err_evt;

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SLV_NUM - 1; i >= 0; i--) begin
            if ((mstr_addr_i & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = slv_ready_i[i];
                sel_rdata = slv_rdata_i[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        err_evt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mstr_valid_i) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        addr_d  = mstr_addr_i;
                        wdata_d = mstr_wdata_i;
                        wstrb_d = mstr_wstrb_i;
                        cnt_d   = '0;
                        state_d = ACTIVE;
                    end else begin
                        rdata_d = ERR_DATA;
                        err_d   = 1'b1;
                        err_evt = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q + 32'd1;
                // A ready arriving on the last allowed cycle still wins over the watchdog.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == TO_LAST)) begin
                    rdata_d = ERR_DATA;
                    err_d   = 1'b1;
                    err_evt = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < SLV_NUM; i++) begin
            slv_valid_o[i] = (state_q == ACTIVE) && (sel_q == SEL_W'(i));
        end
    end

    assign mstr_ready_o = (state_q == RESP);
    assign mstr_rdata_o = rdata_q;
    assign mstr_err_o   = err_q;
    assign slv_addr_o   = addr_q;
    assign slv_wdata_o  = wdata_q;
    assign slv_wstrb_o  = wstrb_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_nmi_xbar_demux.sv
// Randomised self-checking bench for nmi_xbar_demux against a transaction-level model.
module tb_nmi_xbar_demux;

    localparam int          TO      = 8;
    localparam logic [31:0] ERR_W   = 32'hDEAD_BEEF;

    logic          clk;
    logic          rst_n;
    logic          m_valid;
    logic [31:0]   m_addr, m_wdata;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_rdata;
    logic          m_ready, m_err;
    logic [3:0]    s_valid;
    logic [31:0]   s_addr, s_wdata;
    logic [3:0]    s_wstrb;
    logic [127:0]  s_rdata;
    logic [3:0]    s_ready;
    logic [15:0]   err_cnt;

    logic          o_valid;
    logic [31:0]   o_addr;
    logic [31:0]   o_rdata;
    logic          o_ready, o_err;
    logic [3:0]    o_svalid;
    logic [31:0]   o_saddr, o_swdata;
    logic [3:0]    o_swstrb;
    logic [15:0]   o_errcnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_errcnt = 0;

    logic [31:0] base_m [4] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] mask_m [4] = '{32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

    nmi_xbar_demux #(.SLV_NUM(4), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .mstr_valid_i(m_valid), .mstr_addr_i(m_addr), .mstr_wdata_i(m_wdata),
        .mstr_wstrb_i(m_wstrb), .mstr_rdata_o(m_rdata), .mstr_ready_o(m_ready),
        .mstr_err_o(m_err), .slv_valid_o(s_valid), .slv_addr_o(s_addr),
        .slv_wdata_o(s_wdata), .slv_wstrb_o(s_wstrb), .slv_rdata_i(s_rdata),
        .slv_ready_i(s_ready), .err_cnt_o(err_cnt)
    );

    nmi_xbar_demux #(
        .SLV_NUM(4),
        .SLV_BASE({32'h3000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0000_0000}),
        .TIMEOUT_CYC(0)
    ) dut_ov (
        .clk_i(clk), .rst_n_i(rst_n),
        .mstr_valid_i(o_valid), .mstr_addr_i(o_addr), .mstr_wdata_i(32'h0),
        .mstr_wstrb_i(4'h0), .mstr_rdata_o(o_rdata), .mstr_ready_o(o_ready),
        .mstr_err_o(o_err), .slv_valid_o(o_svalid), .slv_addr_o(o_saddr),
        .slv_wdata_o(o_swdata), .slv_wstrb_o(o_swstrb),
        .slv_rdata_i({32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000}),
        .slv_ready_i(4'hF), .err_cnt_o(o_errcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_dec(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & mask_m[i]) == base_m[i]) return i;
        end
        return -1;
    endfunction

    // One master transaction; slave answers after k wait cycles, noise on other slots.
    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int k, input logic [31:0] rd);
        int          idx, exp_lat, exp_act, a_cnt, lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  sel_bit;
        idx = model_dec(a);
        if (idx < 0) begin
            exp_lat = 1; exp_act = 0; exp_err = 1'b1; exp_rd = ERR_W;
        end else if (k < TO) begin
            exp_lat = 2 + k; exp_act = k + 1; exp_err = 1'b0; exp_rd = rd;
        end else begin
            exp_lat = TO + 1; exp_act = TO; exp_err = 1'b1; exp_rd = ERR_W;
        end
        if (exp_err) exp_errcnt = (exp_errcnt < 65535) ? exp_errcnt + 1 : 65535;
        sel_bit = (idx < 0) ? 4'b0000 : 4'(1 << idx);
        @(negedge clk);
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (idx >= 0) s_rdata[idx*32 +: 32] = rd;
        m_addr = a; m_wdata = wd; m_wstrb = ws; m_valid = 1'b1;
        lat = -1; a_cnt = 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            m_valid = 1'b0;
            if (s_valid != 4'b0000) begin
                if (a_cnt == 0) begin
                    chk({tag, "_sel"}, {28'h0, s_valid}, {28'h0, sel_bit});
                    chk({tag, "_addr"}, s_addr, a);
                    chk({tag, "_wdata"}, s_wdata, wd);
                    chk({tag, "_wstrb"}, {28'h0, s_wstrb}, {28'h0, ws});
                end
                a_cnt++;
                s_ready = ((a_cnt == k + 1) ? sel_bit : 4'b0000) | (4'($urandom) & ~sel_bit);
            end else begin
                s_ready = 4'b0000;
            end
            if (m_ready) begin
                lat = c;
                chk({tag, "_rdata"}, m_rdata, exp_rd);
                chk({tag, "_err"}, {31'h0, m_err}, {31'h0, exp_err});
            end
        end
        s_ready = 4'b0000;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_act"}, 32'(a_cnt), 32'(exp_act));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'h0, m_ready}, 32'h0);
        chk({tag, "_hold"}, m_rdata, exp_rd);
        chk({tag, "_errcnt"}, {16'h0, err_cnt}, 32'(exp_errcnt));
    endtask

    initial begin
        int          k;
        logic [31:0] a;
        rst_n = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; s_ready = '0; o_valid = 1'b0; o_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, m_ready}, 32'h0);
        chk("rst_svalid", {28'h0, s_valid}, 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);
        chk("rst_saddr", s_addr, 32'h0);
        chk("rst_errcnt", {16'h0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("rd_hit", 32'h1000_0040, 32'h0, 4'h0, 3, 32'hCAFE_0001);
        run_txn("wr_hit", 32'h3000_0004, 32'h1234_5678, 4'hF, 0, 32'h0BAD_F00D);
        run_txn("miss", 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0);
        run_txn("edge_k7", 32'h0000_0100, 32'h0, 4'h0, TO - 1, 32'h5555_AAAA);
        run_txn("tmo", 32'h2000_0010, 32'h0, 4'h0, 100, 32'h7777_7777);

        @(negedge clk);
        s_ready = 4'b0100;
        @(posedge clk); #1;
        chk("late_svalid", {28'h0, s_valid}, 32'h0);
        chk("late_ready", {31'h0, m_ready}, 32'h0);
        @(negedge clk);
        s_ready = 4'b0000;
        run_txn("after_tmo", 32'h0000_0008, 32'h0, 4'h0, 1, 32'h0123_4567);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            k = $urandom_range(0, 11);
            run_txn("rnd", a, $urandom, 4'($urandom), k, $urandom);
        end

        @(negedge clk);
        o_addr = 32'h1000_0000; o_valid = 1'b1;
        @(posedge clk); #1;
        o_valid = 1'b0;
        chk("ovl_sel", {28'h0, o_svalid}, 32'h2);
        @(posedge clk); #1;
        chk("ovl_ready", {31'h0, o_ready}, 32'h1);
        chk("ovl_rdata", o_rdata, 32'h1111_1111);
        chk("ovl_err", {15'h0, o_errcnt, o_err}, 32'h0);

        @(negedge clk);
        m_addr = 32'h1000_0000; m_wdata = '0; m_wstrb = '0; m_valid = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0;
        @(posedge clk); #1;
        chk("prerst_sel", {28'h0, s_valid}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_errcnt = 0;
        chk("rst_mid_svalid", {28'h0, s_valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, m_ready}, 32'h0);
        chk("rst_mid_errcnt", {16'h0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post_rst", 32'h1000_0020, 32'h0, 4'h0, 2, 32'hFACE_0002);
        run_txn("post_rst_miss", 32'hF000_0000, 32'h0, 4'h0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
